// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-adder evaluation flow: default widths,
// monitor state encoding and a saturating adder used by the statistics counters.
package approx_eval_pkg;

    localparam int unsigned W_DEF     = 16;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned ACC_W_DEF = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    // Adds two values and clamps the result to the all-ones pattern of 'width' bits (<= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [63:0] lim;
        lim = {64{1'b1}} >> (64 - width);
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/err_dist_unit.sv
// Combinational datapath of the monitor: exact reference sum for the incoming
// operands and the unsigned error distance of a registered exact/approx pair.
module err_dist_unit
    import approx_eval_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W:0]   exact_q,
    input  logic [W:0]   approx_q,
    output logic [W:0]   exact,
    output logic [W:0]   ed,
    output logic         ed_nz
);

    always_comb begin
        exact = {1'b0, a} + {1'b0, b};
        // Subtract the smaller from the larger so the distance never wraps.
        if (exact_q >= approx_q) begin
            ed = exact_q - approx_q;
        end else begin
            ed = approx_q - exact_q;
        end
        ed_nz = (ed != '0);
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for an approximate adder: counts samples and errors,
// sums error distance and tracks worst-case error over a run of n_target samples.
module approx_err_monitor
    import approx_eval_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     IN1,
    input  logic [W-1:0]     IN2,
    input  logic [W:0]       approx_sum,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [W:0]       wce
);

    mon_state_e       state;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] n_lat;

    logic             s1_valid;
    logic [W:0]       s1_exact;
    logic [W:0]       s1_approx;
    logic             s2_valid;
    logic [W:0]       s2_ed;
    logic             s2_nz;

    logic [W:0]       exact;
    logic [W:0]       ed;
    logic             ed_nz;
    logic             accept;
    logic             start_ok;

    err_dist_unit #(
        .W (W)
    ) u_edu (
        .a        (IN1),
        .b        (IN2),
        .exact_q  (s1_exact),
        .approx_q (s1_approx),
        .exact    (exact),
        .ed       (ed),
        .ed_nz    (ed_nz)
    );

    always_comb begin
        in_ready = (state == RUN) && (accepted < n_lat);
        done     = (state == DONE);
        accept   = in_valid && in_ready;
        start_ok = start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            accepted   <= '0;
            n_lat      <= '0;
            s1_valid   <= 1'b0;
            s1_exact   <= '0;
            s1_approx  <= '0;
            s2_valid   <= 1'b0;
            s2_ed      <= '0;
            s2_nz      <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            wce        <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exact  <= exact;
                s1_approx <= approx_sum;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed;
                s2_nz <= ed_nz;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        accepted <= '0;
                        n_lat    <= n_target;
                        state    <= (n_target == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        accepted <= accepted + CNT_W'(1);
                        if (accepted + CNT_W'(1) == n_lat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Pipeline is empty whenever start is honoured, so clearing wins outright.
            if (start_ok) begin
                sample_cnt <= '0;
                err_cnt    <= '0;
                ed_sum     <= '0;
                wce        <= '0;
            end else if (s2_valid) begin
                sample_cnt <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
                err_cnt    <= CNT_W'(sat_add(64'(err_cnt), 64'(s2_nz), CNT_W));
                ed_sum     <= ACC_W'(sat_add(64'(ed_sum), 64'(s2_ed), ACC_W));
                if (s2_ed > wce) begin
                    wce <= s2_ed;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed self-checking bench for approx_err_monitor with hand-computed results.
module tb_approx_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] n_target;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] IN1;
    logic [15:0] IN2;
    logic [16:0] approx_sum;
    logic        done;
    logic [31:0] sample_cnt;
    logic [31:0] err_cnt;
    logic [47:0] ed_sum;
    logic [16:0] wce;

    int n_checks = 0;
    int n_pass   = 0;

    approx_err_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_target   (n_target),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IN1        (IN1),
        .IN2        (IN2),
        .approx_sum (approx_sum),
        .done       (done),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .ed_sum     (ed_sum),
        .wce        (wce)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [31:0] n);
        @(negedge clk);
        start    = 1'b1;
        n_target = n;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Present one sample and return just after the edge that consumed it.
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
        bit took;
        took = 1'b0;
        @(negedge clk);
        IN1        = a;
        IN2        = b;
        approx_sum = s;
        in_valid   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                took = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 64'(took), 64'd1);
        @(posedge clk);
    endtask

    task automatic idle_input();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic chk_results(input string tag, input logic [63:0] sc, input logic [63:0] ec,
                               input logic [63:0] es, input logic [63:0] wc);
        chk({tag, "_sample_cnt"}, 64'(sample_cnt), sc);
        chk({tag, "_err_cnt"}, 64'(err_cnt), ec);
        chk({tag, "_ed_sum"}, 64'(ed_sum), es);
        chk({tag, "_wce"}, 64'(wce), wc);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        n_target   = '0;
        in_valid   = 1'b0;
        IN1        = '0;
        IN2        = '0;
        approx_sum = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_results("rst", 0, 0, 0, 0);
        rst = 1'b0;

        // Reset in the middle of a run: 3 samples with ED=3 each are discarded.
        do_start(32'd5);
        chk("run_in_ready", 64'(in_ready), 64'd1);
        push(16'd1, 16'd2, 17'd0);
        push(16'd1, 16'd2, 17'd0);
        push(16'd1, 16'd2, 17'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk_results("midrst", 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("midrst_late_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("midrst_late_ed_sum", 64'(ed_sum), 64'd0);

        // Single exact sample; also checks the two-edge latency.
        do_start(32'd1);
        push(16'd1, 16'd1, 17'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_k_in_ready", 64'(in_ready), 64'd0);
        chk("lat_k_sample_cnt", 64'(sample_cnt), 64'd0);
        @(negedge clk);
        chk("lat_k1_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("lat_k1_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("lat_k2_sample_cnt", 64'(sample_cnt), 64'd1);
        wait_done();
        chk_results("n1", 1, 0, 0, 0);

        // Two back-to-back samples: ED=2 then ED=1.
        do_start(32'd2);
        chk("n2_done_cleared", 64'(done), 64'd0);
        push(16'd3, 16'd3, 17'd4);
        push(16'h0005, 16'h0001, 17'd5);
        @(negedge clk);
        chk("n2_in_ready_drop", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_done();
        chk_results("n2", 2, 2, 3, 2);

        // Carry-out boundary: exact sum 0x1FFFE.
        do_start(32'd2);
        push(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        push(16'hFFFF, 16'hFFFF, 17'h00000);
        idle_input();
        wait_done();
        chk_results("ovf", 2, 1, 64'h1FFFE, 64'h1FFFE);

        // Gapped handshake, start ignored during RUN, surplus sample refused.
        do_start(32'd4);
        push(16'd2, 16'd2, 17'd7);
        idle_input();
        @(negedge clk);
        push(16'd10, 16'd20, 17'd30);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        n_target = 32'd0;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_ignored_done", 64'(done), 64'd0);
        chk("run_start_ignored_ready", 64'(in_ready), 64'd1);
        push(16'd100, 16'd1, 17'd100);
        push(16'd0, 16'd0, 17'd2);
        @(negedge clk);
        IN1        = 16'hFFFF;
        IN2        = 16'hFFFF;
        approx_sum = 17'd0;
        in_valid   = 1'b1;
        chk("hs_extra_ready", 64'(in_ready), 64'd0);
        wait_done();
        in_valid = 1'b0;
        chk_results("hs", 4, 3, 6, 3);

        // Zero-length run, then a restart.
        do_start(32'd0);
        chk("n0_done", 64'(done), 64'd1);
        chk("n0_in_ready", 64'(in_ready), 64'd0);
        chk_results("n0", 0, 0, 0, 0);
        do_start(32'd1);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_in_ready", 64'(in_ready), 64'd1);
        push(16'd7, 16'd8, 17'd15);
        idle_input();
        wait_done();
        chk_results("restart", 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Streaming error-statistics stage placed directly downstream of a 16-bit approximate ripple-carry adder (DUT adder).
- Per sample, takes the operand pair and the adder's 17-bit approximate sum, recomputes the exact sum and derives the error distance (ED).
- Accumulates sample count, error count, ED sum (for MAE) and worst-case error (WCE) over a programmed run, then presents the results with a done flag.
- Used in the power/MAE evaluation flow to characterise each approximate-FA configuration in hardware or simulation.

Parameters:
- W, 16, operand width; sums are W+1 bits.
- CNT_W, 32, width of the sample and error counters and of n_target.
- ACC_W, 48, width of the ED sum accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new run; sampled in IDLE or DONE only.
- n_target  in  CNT_W  number of samples for the run; latched on accepted start.
- in_valid  in  1  sample valid.
- in_ready  out  1  monitor can accept a sample.
- IN1  in  W  operand A presented to the adder.
- IN2  in  W  operand B presented to the adder.
- approx_sum  in  W+1  Out bus of the approximate adder for IN1/IN2.
- done  out  1  run complete; results stable.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with ED != 0.
- ed_sum  out  ACC_W  sum of ED.
- wce  out  W+1  maximum ED seen.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; in_ready=0, done=0, all counters/accumulators/wce=0, pipeline valids cleared. Applies mid-run with no partial results retained.
- States:
  - IDLE -> RUN on start=1. Clears the counters, ed_sum, wce and the accepted count; latches n_target.
  - If the latched n_target==0, go IDLE -> DONE instead.
  - RUN: in_ready=1 while accepted < n_target. Accept on in_valid&in_ready. After the n_target-th accept, in_ready drops in the next cycle and state -> DRAIN.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, then -> DONE.
  - DONE: done=1 and outputs held. start=1 begins a new run (same clears as from IDLE) and drops done in the next cycle.
- start is ignored in RUN and DRAIN.
- Pipeline, 2 stages:
  - S1 registers exact = IN1+IN2 (W+1 bits, zero-extended) and approx_sum.
  - S2 computes ED = |exact - approx_sum|, unsigned W+1 bits, using a compare-then-subtract form (no signed wrap). S2 updates the accumulators.
  - A sample accepted at edge k is reflected in the outputs after edge k+2.
- Updates per S2-valid sample:
  - sample_cnt += 1.
  - err_cnt += (ED != 0).
  - ed_sum += ED.
  - wce = max(wce, ED).
- Saturation: sample_cnt, err_cnt and ed_sum saturate at all-ones and never wrap.
- Outputs are meaningful during RUN (running values) and are guaranteed final only while done=1.
- in_valid with in_ready=0 is not consumed; the upstream source holds the data. No combinational path from in_valid to in_ready.
- Back-to-back accepts every cycle are supported (full throughput).

Decomposition:
- Shared package approx_eval_pkg holds:
  - W, CNT_W, ACC_W defaults.
  - Monitor state enum {IDLE, RUN, DRAIN, DONE}.
  - Saturating-add helper function.
- One sub-module, err_dist_unit: combinational exact add, |diff| and ed_nonzero flag. It is instanced in S1/S2 of approx_err_monitor.

Test Plan:
- Reset mid-run: 3 samples accepted, rst=1 for one cycle -> IDLE, all outputs 0, in_ready=0, done=0.
- n_target=1; IN1=1, IN2=1, approx_sum=2 -> done after drain; sample_cnt=1, err_cnt=0, ed_sum=0, wce=0.
- n_target=2, back-to-back:
  - IN1=3, IN2=3, approx_sum=4 (ED=2).
  - IN1=0x0005, IN2=0x0001, approx_sum=5 (ED=1).
  - -> sample_cnt=2, err_cnt=2, ed_sum=3, wce=2.
  - in_ready=0 one cycle after the 2nd accept.
- Overflow edge: IN1=0xFFFF, IN2=0xFFFF, approx_sum=0x1FFFE -> ED=0. Then approx_sum=0x00000 for the same operands -> ED=0x1FFFE, wce=0x1FFFE.
- Handshake: in_valid toggles with gaps, n_target=4 -> exactly 4 accepts counted. Extra in_valid after the 4th is not accepted. start during RUN is ignored.
- n_target=0 with start -> done=1 on the next cycle, all results 0. A second start with n_target=1 restarts and clears done.
